// File: rtl/sa_operand_feeder_pkg.sv
// Shared constants, FSM state type and small decode helpers for the
// systolic-array operand feeder.
package sa_operand_feeder_pkg;

  localparam int N          = 32;               // element width
  localparam int DIM        = 5;                // array dimension
  localparam int ADDR_W     = 8;                // operand memory address width
  localparam int FIFO_DEPTH = 8;                // per-lane FIFO depth (>= DIM)

  localparam int FETCH_LEN  = DIM * DIM;        // words fetched per run (25)
  localparam int STREAM_LEN = 2 * DIM - 1;      // wavefront length (9)

  localparam int K_W    = $clog2(FETCH_LEN);    // fetch counter width
  localparam int S_W    = $clog2(STREAM_LEN);   // stream counter width
  localparam int LANE_W = $clog2(DIM);          // lane index width
  localparam int PTR_W  = $clog2(FIFO_DEPTH);   // FIFO pointer width
  localparam int CNT_W  = PTR_W + 1;            // FIFO occupancy width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Lane that fetch index k belongs to: its row (k/DIM) for the left-edge
  // channel, its column (k%DIM) for the top-edge channel.
  function automatic logic [LANE_W-1:0] lane_of(input logic [K_W-1:0] k,
                                                input logic           row_major);
    if (row_major) begin
      lane_of = LANE_W'(k / K_W'(DIM));
    end else begin
      lane_of = LANE_W'(k % K_W'(DIM));
    end
  endfunction

  // A lane carries data while 0 <= s - lane <= DIM-1 (the skewed wavefront).
  function automatic logic lane_active(input logic [S_W-1:0] s, input int lane);
    lane_active = (s >= S_W'(lane)) && (s <= S_W'(lane + DIM - 1));
  endfunction

endpackage

// File: rtl/sa_operand_feeder_channel.sv
// One operand channel: local operand memory, one FIFO per lane filled during
// the fetch phase, and skewed output registers drained during the stream phase.
module operand_channel
  import sa_operand_feeder_pkg::*;
#(
  parameter bit ROW_MAJOR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic [K_W-1:0]         fetch_k,
  input  logic [ADDR_W-1:0]      base,
  input  logic                   stream_en,
  input  logic [S_W-1:0]         stream_s,
  output logic [DIM-1:0][N-1:0]  lane_out
);

  // Operand storage; loaded from outside through hierarchy, read-only here.
  logic [N-1:0]        mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]   rd_addr;
  logic [N-1:0]        rd_data;
  logic [LANE_W-1:0]   wr_lane;

  logic [DIM-1:0]      push;
  logic [DIM-1:0]      pop;
  logic [DIM-1:0]      full;
  logic [DIM-1:0]      empty;

  logic [N-1:0]        fifo_mem [DIM][FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr   [DIM];
  logic [PTR_W-1:0]    rd_ptr   [DIM];
  logic [CNT_W-1:0]    count    [DIM];
  logic [DIM-1:0][N-1:0] out_r;

  // Fetch address (wraps modulo memory size), read data and destination lane.
  always_comb begin
    rd_addr = base + ADDR_W'(fetch_k);
    rd_data = mem[rd_addr];
    wr_lane = lane_of(fetch_k, ROW_MAJOR);
  end

  // Per-lane push/pop strobes and occupancy flags.
  always_comb begin
    push  = {DIM{1'b0}};
    pop   = {DIM{1'b0}};
    full  = {DIM{1'b0}};
    empty = {DIM{1'b0}};
    for (int i = 0; i < DIM; i++) begin
      push[i]  = fetch_en && (wr_lane == LANE_W'(i));
      pop[i]   = stream_en && lane_active(stream_s, i);
      full[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
      empty[i] = (count[i] == CNT_W'(0));
    end
  end

  // FIFO payload storage; no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DIM; i++) begin
      if (push[i]) begin
        fifo_mem[i][wr_ptr[i]] <= rd_data;
      end
    end
  end

  // FIFO pointers, occupancy and skewed output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DIM; i++) begin
        wr_ptr[i] <= PTR_W'(0);
        rd_ptr[i] <= PTR_W'(0);
        count[i]  <= CNT_W'(0);
      end
      out_r <= {(DIM*N){1'b0}};
    end else begin
      for (int i = 0; i < DIM; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end else begin
          wr_ptr[i] <= wr_ptr[i];
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
          out_r[i]  <= fifo_mem[i][rd_ptr[i]];
        end else begin
          rd_ptr[i] <= rd_ptr[i];
          out_r[i]  <= {N{1'b0}};
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign lane_out = out_r;

  operand_channel_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .full  (full),
    .empty (empty)
  );

endmodule

// Protocol checks for the lane FIFOs: a push into a full FIFO or a pop from
// an empty one means the fetch/stream sequencing has gone wrong.
module operand_channel_chk
  import sa_operand_feeder_pkg::*;
(
  input logic           clk,
  input logic           rst,
  input logic [DIM-1:0] push,
  input logic [DIM-1:0] pop,
  input logic [DIM-1:0] full,
  input logic [DIM-1:0] empty
);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(push[i] && full[i]));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
      !(pop[i] && empty[i]));
  end

endmodule

// File: rtl/sa_operand_feeder_top.sv
// Operand front end of a 5x5 systolic array: one shared FSM sequences a
// 25-word fetch into both channels, then a 9-cycle skewed stream out.
module sa_operand_feeder_top
  import sa_operand_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [ADDR_W-1:0] base_address_A,
  input  logic [ADDR_W-1:0] base_address_B,
  output logic [N-1:0]      A0_out,
  output logic [N-1:0]      A1_out,
  output logic [N-1:0]      A2_out,
  output logic [N-1:0]      A3_out,
  output logic [N-1:0]      A4_out,
  output logic [N-1:0]      B0_out,
  output logic [N-1:0]      B1_out,
  output logic [N-1:0]      B2_out,
  output logic [N-1:0]      B3_out,
  output logic [N-1:0]      B4_out
);

  state_t                state;
  logic [K_W-1:0]        fetch_k;
  logic [S_W-1:0]        stream_s;
  logic [ADDR_W-1:0]     base_a;
  logic [ADDR_W-1:0]     base_b;
  logic                  fetch_en;
  logic                  stream_en;
  logic [DIM-1:0][N-1:0] a_lanes;
  logic [DIM-1:0][N-1:0] b_lanes;

  // Sequencer: latch bases on init in IDLE, count fetch words then stream beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_k  <= K_W'(0);
      stream_s <= S_W'(0);
      base_a   <= ADDR_W'(0);
      base_b   <= ADDR_W'(0);
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            base_a  <= base_address_A;
            base_b  <= base_address_B;
            fetch_k <= K_W'(0);
            state   <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        FETCH: begin
          if (fetch_k == K_W'(FETCH_LEN - 1)) begin
            fetch_k  <= K_W'(0);
            stream_s <= S_W'(0);
            state    <= STREAM;
          end else begin
            fetch_k <= fetch_k + K_W'(1);
          end
        end
        STREAM: begin
          if (stream_s == S_W'(STREAM_LEN - 1)) begin
            stream_s <= S_W'(0);
            state    <= IDLE;
          end else begin
            stream_s <= stream_s + S_W'(1);
          end
        end
        default: begin
          fetch_k  <= K_W'(0);
          stream_s <= S_W'(0);
          state    <= IDLE;
        end
      endcase
    end
  end

  // Phase enables broadcast to both channels.
  always_comb begin
    fetch_en  = 1'b0;
    stream_en = 1'b0;
    case (state)
      FETCH:   fetch_en  = 1'b1;
      STREAM:  stream_en = 1'b1;
      default: begin
        fetch_en  = 1'b0;
        stream_en = 1'b0;
      end
    endcase
  end

  operand_channel #(.ROW_MAJOR(1'b1)) u_chan_a (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .fetch_k   (fetch_k),
    .base      (base_a),
    .stream_en (stream_en),
    .stream_s  (stream_s),
    .lane_out  (a_lanes)
  );

  operand_channel #(.ROW_MAJOR(1'b0)) u_chan_b (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .fetch_k   (fetch_k),
    .base      (base_b),
    .stream_en (stream_en),
    .stream_s  (stream_s),
    .lane_out  (b_lanes)
  );

  assign A0_out = a_lanes[0];
  assign A1_out = a_lanes[1];
  assign A2_out = a_lanes[2];
  assign A3_out = a_lanes[3];
  assign A4_out = a_lanes[4];
  assign B0_out = b_lanes[0];
  assign B1_out = b_lanes[1];
  assign B2_out = b_lanes[2];
  assign B3_out = b_lanes[3];
  assign B4_out = b_lanes[4];

endmodule

// File: tb/tb_sa_operand_feeder_top.sv
// Directed bench for sa_operand_feeder_top: reset, identity run, base wrap,
// ignored re-init, mid-run reset and independent channel patterns.
module tb_sa_operand_feeder_top;
  import sa_operand_feeder_pkg::*;

  logic        clk;
  logic        rst;
  logic        init;
  logic [7:0]  base_address_A;
  logic [7:0]  base_address_B;
  logic [31:0] a_o [5];
  logic [31:0] b_o [5];

  logic [31:0] mem_a_m [256];
  logic [31:0] mem_b_m [256];
  logic [31:0] cap_a [36][5];
  logic [31:0] cap_b [36][5];

  int n_cmp = 0;
  int n_err = 0;

  sa_operand_feeder_top dut (
    .clk            (clk),
    .rst            (rst),
    .init           (init),
    .base_address_A (base_address_A),
    .base_address_B (base_address_B),
    .A0_out         (a_o[0]),
    .A1_out         (a_o[1]),
    .A2_out         (a_o[2]),
    .A3_out         (a_o[3]),
    .A4_out         (a_o[4]),
    .B0_out         (b_o[0]),
    .B1_out         (b_o[1]),
    .B2_out         (b_o[2]),
    .B3_out         (b_o[3]),
    .B4_out         (b_o[4])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_A%0d", tag, i), a_o[i], 32'd0);
      chk($sformatf("%s_B%0d", tag, i), b_o[i], 32'd0);
    end
  endtask

  task automatic load_identity();
    for (int a = 0; a < 256; a++) begin
      mem_a_m[a] = 32'(a);
      mem_b_m[a] = 32'(a);
      dut.u_chan_a.mem[a] = 32'(a);
      dut.u_chan_b.mem[a] = 32'(a);
    end
  endtask

  task automatic load_patterns();
    for (int a = 0; a < 256; a++) begin
      mem_a_m[a] = 32'hA500_0000 + 32'(a * 3);
      mem_b_m[a] = 32'hB600_0000 + 32'(a * 7);
      dut.u_chan_a.mem[a] = mem_a_m[a];
      dut.u_chan_b.mem[a] = mem_b_m[a];
    end
  endtask

  // One run: init at E0, optional extra init pulses and a reset edge, then
  // every lane is compared against the matrix/skew expectation for E1..E35.
  task automatic do_run(input string tag, input logic [7:0] ba, input logic [7:0] bb,
                        input int re1, input int re2, input int rst_e);
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int s;
    int d;
    base_address_A = ba;
    base_address_B = bb;
    init = 1'b1;
    step();
    init = 1'b0;
    base_address_A = ~ba;
    base_address_B = ~bb;
    for (int e = 1; e <= 35; e++) begin
      init = (e == re1) || (e == re2);
      rst  = (e == rst_e) ? 1'b0 : 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
        cap_a[e][i] = a_o[i];
        cap_b[e][i] = b_o[i];
        exp_a = 32'd0;
        exp_b = 32'd0;
        if (!(rst_e > 0 && e >= rst_e) && e >= 26) begin
          s = e - 26;
          d = s - i;
          if (d >= 0 && d <= 4) begin
            exp_a = mem_a_m[8'(ba + 5 * i + d)];
            exp_b = mem_b_m[8'(bb + 5 * d + i)];
          end
        end
        chk($sformatf("%s_A%0d_e%0d", tag, i, e), a_o[i], exp_a);
        chk($sformatf("%s_B%0d_e%0d", tag, i, e), b_o[i], exp_b);
      end
    end
    init = 1'b0;
    rst  = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    init = 1'b0;
    base_address_A = 8'd0;
    base_address_B = 8'd0;

    // Reset with random init
    for (int c = 0; c < 2; c++) begin
      init = 1'($urandom_range(0, 1));
      step();
    end
    chk_all_zero("rst");
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b1;
    init = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      chk_all_zero($sformatf("idle_c%0d", c));
    end

    // Identity pattern, bases 0
    load_identity();
    do_run("id", 8'd0, 8'd0, -1, -1, -1);
    chk("id_e26_A0", cap_a[26][0], 32'd0);
    chk("id_e27_A0", cap_a[27][0], 32'd1);
    chk("id_e27_A1", cap_a[27][1], 32'd5);
    chk("id_e27_B0", cap_b[27][0], 32'd5);
    chk("id_e27_B1", cap_b[27][1], 32'd1);
    chk("id_e30_A0", cap_a[30][0], 32'd4);
    chk("id_e30_A4", cap_a[30][4], 32'd20);
    chk("id_e30_B4", cap_b[30][4], 32'd4);
    chk("id_e34_A4", cap_a[34][4], 32'd24);
    chk("id_e34_B4", cap_b[34][4], 32'd24);
    chk("id_e35_A4", cap_a[35][4], 32'd0);

    // Base offset with address wrap
    do_run("wrap", 8'd250, 8'd0, -1, -1, -1);
    chk("wrap_e27_A1", cap_a[27][1], 32'd255);
    chk("wrap_e28_A1", cap_a[28][1], 32'd0);
    chk("wrap_e28_A2", cap_a[28][2], 32'd4);

    // init pulses during FETCH and STREAM are ignored
    do_run("reinit", 8'd0, 8'd0, 10, 28, -1);
    chk("reinit_e27_A1", cap_a[27][1], 32'd5);
    chk("reinit_e34_B4", cap_b[34][4], 32'd24);

    // Independent channels with distinct patterns and bases
    load_patterns();
    do_run("indep", 8'h10, 8'h80, 34, -1, -1);
    chk("indep_e26_A0", cap_a[26][0], 32'hA500_0030);
    chk("indep_e26_B0", cap_b[26][0], 32'hB600_0380);
    chk("indep_e27_B1", cap_b[27][1], 32'hB600_0387);
    // init seen at E34 (STREAM) must not start another run
    for (int c = 0; c < 40; c++) begin
      step();
      chk_all_zero($sformatf("post_c%0d", c));
    end

    // Reset in the middle of the stream, then a clean run
    do_run("mrst", 8'h10, 8'h80, -1, -1, 30);
    chk("mrst_state", 32'(dut.state), 32'(IDLE));
    do_run("after", 8'h10, 8'h80, -1, -1, -1);

    // Reset and init asserted together: reset wins
    rst = 1'b0;
    init = 1'b1;
    step();
    rst = 1'b1;
    init = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      chk_all_zero($sformatf("rstinit_c%0d", c));
    end
    chk("rstinit_state", 32'(dut.state), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
